mc_maindec: RTL and testbench

Multicycle main controller for the MIPS core: a Moore/Mealy FSM that replaces the single-cycle combinational decoder, sequencing each instruction over several cycles through one shared memory port with a ready handshake. Adds bne/ori (parameter-selectable), a defined trap for illegal opcodes, and a retired-instruction counter. Sits between the instruction register's opcode field and the multicycle datapath/memory interface.

---
 rtl/mc_maindec.sv | 249 ++++++++++++++++++++++++
 tb/tb_mc_maindec.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// -----------------------------------------------------------------------------
// mc_maindec -- multicycle main controller for the MIPS core.
//
// Sequences each instruction over several cycles through a single shared
// memory port (request held until mem_ready). Control outputs are decoded from
// the current state; FETCH's irwrite/pcwrite follow mem_ready in the same cycle.
// Illegal opcodes (including bne/ori when disabled by parameter) enter an
// absorbing TRAP state. A retired-instruction counter wraps modulo 2^CNT_W.
//
// Parameters:
//   EN_BNE    1 = opcode 000101 executes as bne, 0 = traps
//   EN_ORI    1 = opcode 001101 executes as ori, 0 = traps
//   CNT_W     width of the retired-instruction counter
// Ports:
//   clk, reset_n (async, active low)
//   op         opcode field from the instruction register
//   mem_ready  memory completes the current access this cycle
//   mem_req, iord, memwrite, irwrite, pcwrite, regwrite
//   branch, branch_ne, alusrca, regdst, memtoreg, zeroext
//   alusrcb, pcsrc, aluop (2 bits each)
//   trap       illegal opcode seen, sticky until reset
//   instret    completed-instruction count
// -----------------------------------------------------------------------------
module mc_maindec #(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_ORI = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             regwrite,
    output logic             branch,
    output logic             branch_ne,
    output logic             alusrca,
    output logic             regdst,
    output logic             memtoreg,
    output logic             zeroext,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [1:0]       aluop,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Dispatch target out of DECODE, taken from the live opcode.
    function automatic state_t decode_target(input logic [5:0] opc);
        state_t t;
        case (opc)
            OP_LW, OP_SW: t = S_MEMADR;
            OP_R:         t = S_EXEC;
            OP_BEQ:       t = S_BRANCH;
            OP_BNE:       t = EN_BNE ? S_BRANCH : S_TRAP;
            OP_ADDI:      t = S_IEXEC;
            OP_ORI:       t = EN_ORI ? S_IEXEC : S_TRAP;
            OP_J:         t = S_JUMP;
            default:      t = S_TRAP;
        endcase
        return t;
    endfunction

    // Next state; retire marks the final cycle of a completed instruction.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = decode_target(op);
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_IEXEC:  state_d = S_IWB;
            S_IWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            // The opcode is latched on leaving DECODE; later states ignore op.
            if (state_q == S_DECODE) begin
                op_q <= op;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_ONE;
            end
        end
    end

    assign instret = instret_q;

    // Control decode. Everything is held at zero while reset_n is low so the
    // datapath sees no request or write even in the reset cycle itself.
    always_comb begin
        mem_req   = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        regwrite  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        alusrca   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        zeroext   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        trap      = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    // IR and PC+4 are written in the cycle the fetch completes.
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca   = 1'b1;
                    aluop     = 2'b01;
                    pcsrc     = 2'b01;
                    branch    = (op_q == OP_BEQ);
                    branch_ne = (op_q == OP_BNE);
                end
                S_IEXEC: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    if (op_q == OP_ORI) begin
                        aluop   = 2'b11;
                        zeroext = 1'b1;
                    end
                end
                S_IWB: begin
                    regwrite = 1'b1;
                end
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    trap = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_maindec.sv
module tb_mc_maindec;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Instruction phases as described behaviourally by the controller table.
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_IEX = 9, P_IWB = 10;
    localparam int P_J = 11, P_TR = 12;

    logic clk;
    logic reset_n_a, reset_n_b;
    logic [5:0] op;
    logic mem_ready;
    logic sel;  // 0: default instance, 1: EN_BNE=0/EN_ORI=0/CNT_W=4 instance

    logic mem_req_a, iord_a, memwrite_a, irwrite_a, pcwrite_a, regwrite_a;
    logic branch_a, branch_ne_a, alusrca_a, regdst_a, memtoreg_a, zeroext_a, trap_a;
    logic [1:0] alusrcb_a, pcsrc_a, aluop_a;
    logic [31:0] cnt_a;

    logic mem_req_b, iord_b, memwrite_b, irwrite_b, pcwrite_b, regwrite_b;
    logic branch_b, branch_ne_b, alusrca_b, regdst_b, memtoreg_b, zeroext_b, trap_b;
    logic [1:0] alusrcb_b, pcsrc_b, aluop_b;
    logic [3:0] cnt_b;

    mc_maindec dut_a (
        .clk(clk), .reset_n(reset_n_a), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req_a), .iord(iord_a), .memwrite(memwrite_a),
        .irwrite(irwrite_a), .pcwrite(pcwrite_a), .regwrite(regwrite_a),
        .branch(branch_a), .branch_ne(branch_ne_a), .alusrca(alusrca_a),
        .regdst(regdst_a), .memtoreg(memtoreg_a), .zeroext(zeroext_a),
        .alusrcb(alusrcb_a), .pcsrc(pcsrc_a), .aluop(aluop_a),
        .trap(trap_a), .instret(cnt_a)
    );

    mc_maindec #(.EN_BNE(1'b0), .EN_ORI(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req_b), .iord(iord_b), .memwrite(memwrite_b),
        .irwrite(irwrite_b), .pcwrite(pcwrite_b), .regwrite(regwrite_b),
        .branch(branch_b), .branch_ne(branch_ne_b), .alusrca(alusrca_b),
        .regdst(regdst_b), .memtoreg(memtoreg_b), .zeroext(zeroext_b),
        .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .aluop(aluop_b),
        .trap(trap_b), .instret(cnt_b)
    );

    wire [18:0] obs_a = {mem_req_a, iord_a, memwrite_a, irwrite_a, pcwrite_a, regwrite_a,
                         branch_a, branch_ne_a, alusrca_a, regdst_a, memtoreg_a, zeroext_a,
                         trap_a, alusrcb_a, pcsrc_a, aluop_a};
    wire [18:0] obs_b = {mem_req_b, iord_b, memwrite_b, irwrite_b, pcwrite_b, regwrite_b,
                         branch_b, branch_ne_b, alusrca_b, regdst_b, memtoreg_b, zeroext_b,
                         trap_b, alusrcb_b, pcsrc_b, aluop_b};
    wire [18:0] obs     = sel ? obs_b : obs_a;
    wire [31:0] cnt_obs = sel ? {28'd0, cnt_b} : cnt_a;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_instret();
        return sel ? (32'(exp_cnt) & 32'hF) : 32'(exp_cnt);
    endfunction

    // Expected control word for one phase, straight from the state/output table.
    function automatic logic [18:0] exp_ctrl(input int ph, input logic [5:0] o, input logic mr);
        logic mreq, io, mw, irw, pcw, rw, br, bn, asa, rd, m2r, ze, tr;
        logic [1:0] asb, pcs, aop;
        {mreq, io, mw, irw, pcw, rw, br, bn, asa, rd, m2r, ze, tr} = 13'd0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (ph)
            P_F:   begin mreq = 1; asb = 2'b01; irw = mr; pcw = mr; end
            P_D:   asb = 2'b11;
            P_MA:  begin asa = 1; asb = 2'b10; end
            P_MR:  begin mreq = 1; io = 1; end
            P_MWB: begin m2r = 1; rw = 1; end
            P_MW:  begin mreq = 1; io = 1; mw = 1; end
            P_EX:  begin asa = 1; aop = 2'b10; end
            P_AWB: begin rd = 1; rw = 1; end
            P_BR:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = (o == OP_BEQ); bn = (o == OP_BNE); end
            P_IEX: begin asa = 1; asb = 2'b10; if (o == OP_ORI) begin aop = 2'b11; ze = 1; end end
            P_IWB: rw = 1;
            P_J:   begin pcs = 2'b10; pcw = 1; end
            P_TR:  tr = 1;
            default: ;
        endcase
        return {mreq, io, mw, irw, pcw, rw, br, bn, asa, rd, m2r, ze, tr, asb, pcs, aop};
    endfunction

    // Runs one instruction: fw wait cycles in FETCH, mw in MEMRD/MEMWR,
    // trap_cycles observed in TRAP, stop_after>=0 abandons it after that many cycles.
    // Entry and exit point: 1 time unit after a rising edge.
    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw,
                             input int trap_cycles, input int stop_after);
        int ph[$];
        int n;
        int total;
        logic mr;
        logic [18:0] e;
        bit en_bne;
        bit en_ori;
        en_bne = !sel;
        en_ori = !sel;
        case (opc)
            OP_R:    ph = '{P_F, P_D, P_EX, P_AWB};
            OP_LW:   ph = '{P_F, P_D, P_MA, P_MR, P_MWB};
            OP_SW:   ph = '{P_F, P_D, P_MA, P_MW};
            OP_BEQ:  ph = '{P_F, P_D, P_BR};
            OP_BNE:  ph = en_bne ? '{P_F, P_D, P_BR} : '{P_F, P_D, P_TR};
            OP_ADDI: ph = '{P_F, P_D, P_IEX, P_IWB};
            OP_ORI:  ph = en_ori ? '{P_F, P_D, P_IEX, P_IWB} : '{P_F, P_D, P_TR};
            OP_J:    ph = '{P_F, P_D, P_J};
            default: ph = '{P_F, P_D, P_TR};
        endcase
        total = 0;
        foreach (ph[i]) begin
            if (ph[i] == P_F) n = fw + 1;
            else if (ph[i] == P_MR || ph[i] == P_MW) n = mw + 1;
            else if (ph[i] == P_TR) n = trap_cycles;
            else n = 1;
            for (int k = 0; k < n; k++) begin
                if (stop_after >= 0 && total == stop_after) return;
                if (ph[i] == P_F || ph[i] == P_MR || ph[i] == P_MW)
                    mr = (k == n - 1);
                else
                    mr = 1'($urandom_range(0, 1));
                op = (ph[i] == P_F || ph[i] == P_D) ? opc : 6'($urandom);
                mem_ready = mr;
                @(negedge clk);
                e = exp_ctrl(ph[i], opc, mr);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL ctrl op=%b phase=%0d cyc=%0d got=%b exp=%b", opc, ph[i], cyc, obs, e);
                end
                @(posedge clk);
                #1;
                total++;
            end
        end
        if (ph[ph.size() - 1] != P_TR) exp_cnt++;
        checks++;
        if (cnt_obs !== exp_instret()) begin
            errors++;
            $display("FAIL instret op=%b got=%0d exp=%0d", opc, cnt_obs, exp_instret());
        end
        $display("instr op=%b fw=%0d mw=%0d instret=%0d", opc, fw, mw, cnt_obs);
    endtask

    // Release the selected instance from reset with mem_ready low, leaving
    // the other instance held in reset.
    task automatic release_reset(input logic which);
        sel = which;
        mem_ready = 1'b0;
        @(negedge clk);
        if (which) reset_n_b = 1'b1; else reset_n_a = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            op = 6'($urandom);
            @(negedge clk);
            checks++;
            if (obs_a !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs got=%b exp=0", obs_a);
            end
            checks++;
            if (cnt_a !== 32'd0) begin
                errors++;
                $display("FAIL reset_instret got=%0d exp=0", cnt_a);
            end
        end
        release_reset(1'b0);
        $display("reset released instret=%0d", cnt_a);
    endtask

    task automatic test_rtype();
        run_instr(OP_R, 0, 0, 0, -1);
        checks++;
        if (cnt_a !== 32'd1) begin
            errors++;
            $display("FAIL rtype_instret got=%0d exp=1", cnt_a);
        end
    endtask

    task automatic test_lw_waits();
        int t0;
        t0 = cyc;
        run_instr(OP_LW, 2, 3, 0, -1);
        checks++;
        if (cyc - t0 !== 10) begin
            errors++;
            $display("FAIL lw_latency got=%0d exp=10", cyc - t0);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [6];
        int base;
        seq = '{OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI};
        base = exp_cnt;
        for (int i = 0; i < 6; i++) run_instr(seq[i], 0, 0, 0, -1);
        checks++;
        if (cnt_a !== 32'(base + 6)) begin
            errors++;
            $display("FAIL b2b_instret got=%0d exp=%0d", cnt_a, base + 6);
        end
    endtask

    task automatic test_random_stream();
        logic [5:0] ops [8];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
        for (int i = 0; i < 30; i++)
            run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
    endtask

    task automatic test_trap_disabled();
        reset_n_a = 1'b0;
        release_reset(1'b1);
        run_instr(OP_R, 1, 0, 0, -1);
        run_instr(OP_BNE, 0, 0, 6, -1);
        run_instr(OP_ORI, 0, 0, 4, 0);  // stays in TRAP: checked via instret only
        checks++;
        if (cnt_b !== 4'd1 || trap_b !== 1'b1) begin
            errors++;
            $display("FAIL trap_bne cnt=%0d trap=%b exp cnt=1 trap=1", cnt_b, trap_b);
        end
        reset_n_b = 1'b0;
        #1;
        checks++;
        if (obs_b !== 19'd0) begin
            errors++;
            $display("FAIL trap_clear got=%b exp=0", obs_b);
        end
    endtask

    task automatic test_illegal_and_abort();
        release_reset(1'b0);
        run_instr(6'b111111, 0, 0, 5, -1);
        checks++;
        if (trap_a !== 1'b1 || mem_req_a !== 1'b0) begin
            errors++;
            $display("FAIL illegal_trap trap=%b mem_req=%b exp 1/0", trap_a, mem_req_a);
        end
        reset_n_a = 1'b0;
        release_reset(1'b0);
        run_instr(OP_R, 0, 0, 0, -1);
        // Abort a store while it waits in MEMWR.
        run_instr(OP_SW, 0, 5, 0, 5);
        reset_n_a = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs_a !== 19'd0 || cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL abort_memwr got=%b cnt=%0d exp 0/0", obs_a, cnt_a);
        end
        release_reset(1'b0);
        run_instr(OP_R, 0, 0, 0, -1);
    endtask

    task automatic test_wrap();
        reset_n_a = 1'b0;
        release_reset(1'b1);
        for (int i = 0; i < 17; i++) run_instr(OP_J, $urandom_range(0, 1), 0, 0, -1);
        checks++;
        if (cnt_b !== 4'd1) begin
            errors++;
            $display("FAIL wrap got=%0d exp=1", cnt_b);
        end
    endtask

    initial begin
        op = 6'd0;
        mem_ready = 1'b0;
        sel = 1'b0;
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        test_reset();
        test_rtype();
        test_lw_waits();
        test_back_to_back();
        test_random_stream();
        test_trap_disabled();
        test_illegal_and_abort();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
